// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, realigns synchronous-read memory words with their
// addresses and holds one in-flight word in a skid buffer while decode stalls.
module instruction_fetch #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int RESET_ADDR = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  branch_taken,
  input  logic [ADDR_WIDTH-1:0] branch_target,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic [DATA_WIDTH-1:0] instr_out,
  output logic [ADDR_WIDTH-1:0] pc_out,
  output logic                  instr_valid
);

  logic [ADDR_WIDTH-1:0] pc, fetch_pc, skid_pc;
  logic [DATA_WIDTH-1:0] skid_instr;
  logic                  fetch_valid, skid_valid;

  assign mem_addr = pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= ADDR_WIDTH'(RESET_ADDR);
      fetch_pc    <= '0;
      fetch_valid <= 1'b0;
      skid_instr  <= '0;
      skid_pc     <= '0;
      skid_valid  <= 1'b0;
      instr_out   <= '0;
      pc_out      <= '0;
      instr_valid <= 1'b0;
    end else if (branch_taken) begin
      // Everything in flight belongs to the wrong path; outputs keep stale data.
      pc          <= branch_target;
      fetch_valid <= 1'b0;
      skid_valid  <= 1'b0;
      instr_valid <= 1'b0;
    end else if (stall) begin
      fetch_valid <= 1'b0;
      // Only the first stall cycle can have a live memory word to capture.
      if (fetch_valid && !skid_valid) begin
        skid_instr <= mem_data;
        skid_pc    <= fetch_pc;
        skid_valid <= 1'b1;
      end
    end else begin
      if (skid_valid) begin
        instr_out <= skid_instr;
        pc_out    <= skid_pc;
      end else if (fetch_valid) begin
        instr_out <= mem_data;
        pc_out    <= fetch_pc;
      end
      instr_valid <= skid_valid | fetch_valid;
      skid_valid  <= 1'b0;
      fetch_pc    <= pc;
      fetch_valid <= 1'b1;
      pc          <= pc + ADDR_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: a vector table for the main stream
// plus a mid-stream async reset and a second instance starting near the wrap.
module tb_instruction_fetch;
  localparam int DW = 32;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst, stall, branch_taken;
  logic [AW-1:0] branch_target;
  logic [AW-1:0] mem_addr, pc_out, w_mem_addr, w_pc_out;
  logic [DW-1:0] mem_data, instr_out, w_mem_data, w_instr_out;
  logic          instr_valid, w_instr_valid;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  instruction_fetch #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RESET_ADDR(0)) dut (
    .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .mem_addr(mem_addr), .mem_data(mem_data),
    .instr_out(instr_out), .pc_out(pc_out), .instr_valid(instr_valid)
  );

  instruction_fetch #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RESET_ADDR(1022)) u_wrap (
    .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .mem_addr(w_mem_addr), .mem_data(w_mem_data),
    .instr_out(w_instr_out), .pc_out(w_pc_out), .instr_valid(w_instr_valid)
  );

  function automatic logic [DW-1:0] word(input logic [AW-1:0] a);
    return 32'h16E0_0C00 + ({22'd0, a} << 16) + {22'd0, a};
  endfunction

  // Synchronous-read instruction memories
  always @(posedge clk) begin
    mem_data   <= word(mem_addr);
    w_mem_data <= word(w_mem_addr);
  end

  typedef struct {
    logic          stall, br;
    logic [AW-1:0] tgt;
    logic          vld;
    logic [AW-1:0] pc;
    logic [DW-1:0] ins;
    logic [AW-1:0] addr;
    logic          chk_w;
    logic          wvld;
    logic [AW-1:0] wpc;
    logic [DW-1:0] wins;
  } vec_t;

  vec_t tbl[$];
  vec_t tbl2[$];

  function automatic vec_t mk(input logic s, input logic b, input logic [AW-1:0] t,
                              input logic v, input logic [AW-1:0] p,
                              input logic [DW-1:0] i, input logic [AW-1:0] a);
    vec_t r;
    r.stall = s; r.br = b; r.tgt = t; r.vld = v; r.pc = p; r.ins = i; r.addr = a;
    r.chk_w = 1'b0; r.wvld = 1'b0; r.wpc = '0; r.wins = '0;
    return r;
  endfunction

  function automatic vec_t mkw(input vec_t base, input logic v, input logic [AW-1:0] p,
                               input logic [DW-1:0] i);
    vec_t r;
    r = base; r.chk_w = 1'b1; r.wvld = v; r.wpc = p; r.wins = i;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic run(input vec_t v, input int idx);
    stall = v.stall; branch_taken = v.br; branch_target = v.tgt;
    @(posedge clk); #1;
    chk($sformatf("vld[%0d]", idx),  64'(instr_valid), 64'(v.vld));
    chk($sformatf("pc[%0d]", idx),   64'(pc_out),      64'(v.pc));
    chk($sformatf("ins[%0d]", idx),  64'(instr_out),   64'(v.ins));
    chk($sformatf("addr[%0d]", idx), 64'(mem_addr),    64'(v.addr));
    if (v.chk_w) begin
      chk($sformatf("wrap_vld[%0d]", idx), 64'(w_instr_valid), 64'(v.wvld));
      chk($sformatf("wrap_pc[%0d]", idx),  64'(w_pc_out),      64'(v.wpc));
      chk($sformatf("wrap_ins[%0d]", idx), 64'(w_instr_out),   64'(v.wins));
    end
  endtask

  initial begin
    // Main stream: free-run, 3-cycle stall, branch, branch during stall
    tbl.push_back(mk(0, 0, 0,  0, 0,  0,        1));
    tbl.push_back(mk(0, 0, 0,  1, 0,  word(0),  2));
    tbl.push_back(mk(0, 0, 0,  1, 1,  word(1),  3));
    tbl.push_back(mk(1, 0, 0,  1, 1,  word(1),  3));
    tbl.push_back(mk(1, 0, 0,  1, 1,  word(1),  3));
    tbl.push_back(mk(1, 0, 0,  1, 1,  word(1),  3));
    tbl.push_back(mk(0, 0, 0,  1, 2,  word(2),  4));
    tbl.push_back(mk(0, 0, 0,  1, 3,  word(3),  5));
    tbl.push_back(mk(0, 1, 20, 0, 3,  word(3),  20));
    tbl.push_back(mk(0, 0, 0,  0, 3,  word(3),  21));
    tbl.push_back(mk(0, 0, 0,  1, 20, word(20), 22));
    tbl.push_back(mk(0, 0, 0,  1, 21, word(21), 23));
    tbl.push_back(mk(1, 0, 0,  1, 21, word(21), 23));
    tbl.push_back(mk(1, 1, 8,  0, 21, word(21), 8));
    tbl.push_back(mk(1, 0, 0,  0, 21, word(21), 8));
    tbl.push_back(mk(0, 0, 0,  0, 21, word(21), 9));
    tbl.push_back(mk(0, 0, 0,  1, 8,  word(8),  10));
    tbl.push_back(mk(0, 0, 0,  1, 9,  word(9),  11));
    tbl.push_back(mk(1, 0, 0,  1, 9,  word(9),  11));

    // After the mid-stream reset: refetch from 0, and the 1022 instance wraps
    tbl2.push_back(mkw(mk(0, 0, 0, 0, 0, 0,       1), 0, 0,    0));
    tbl2.push_back(mkw(mk(0, 0, 0, 1, 0, word(0), 2), 1, 1022, word(1022)));
    tbl2.push_back(mkw(mk(0, 0, 0, 1, 1, word(1), 3), 1, 1023, word(1023)));
    tbl2.push_back(mkw(mk(0, 0, 0, 1, 2, word(2), 4), 1, 0,    word(0)));
    tbl2.push_back(mkw(mk(0, 0, 0, 1, 3, word(3), 5), 1, 1,    word(1)));

    rst = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_vld",    64'(instr_valid), 64'(0));
    chk("rst_pc",     64'(pc_out),      64'(0));
    chk("rst_ins",    64'(instr_out),   64'(0));
    chk("rst_addr",   64'(mem_addr),    64'(0));
    chk("rst_waddr",  64'(w_mem_addr),  64'(1022));
    chk("rst_wvld",   64'(w_instr_valid), 64'(0));
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) run(tbl[i], i);

    // Async reset between edges while the skid buffer is full
    #2 rst = 1'b1;
    #1;
    chk("arst_vld",   64'(instr_valid), 64'(0));
    chk("arst_pc",    64'(pc_out),      64'(0));
    chk("arst_ins",   64'(instr_out),   64'(0));
    chk("arst_addr",  64'(mem_addr),    64'(0));
    chk("arst_waddr", 64'(w_mem_addr),  64'(1022));
    #2 rst = 1'b0;

    for (int i = 0; i < tbl2.size(); i++) run(tbl2[i], 100 + i);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
